pga_serial_rx: RTL and testbench
================================

Name: pga_serial_rx

Overview:
Receive-side decoder for the two-wire PGA serial link (pga_clk/pga_dat) that pga_control drives.
- Samples pga_dat on rising edges of pga_clk, frames and checks 10-bit command words, and holds the decoded offset/gain/measure state.
- Sits on the clk25 domain alongside pga_control. Used as a loopback monitor for the on-board PGA bus and as the behavioural responder in PGA bring-up.
- Reports each command with a one-cycle strobe. Reports malformed frames with an error pulse and code.

Parameters:
IDLE_TIMEOUT, 64, clk25 cycles with no pga_clk rising edge that ends a partial frame or an error drain.
TO_WIDTH, 7, counter width for IDLE_TIMEOUT; must satisfy 2^TO_WIDTH > IDLE_TIMEOUT.

Ports:
clk25  input  1  system clock, all logic on rising edge
wb_rst_n  input  1  synchronous, active-low reset
pga_dat  input  1  serial data from the PGA bus, asynchronous to clk25
pga_clk  input  1  serial clock from the PGA bus, asynchronous to clk25, idles low
offset_out  output  5  last accepted Vos offset
gain_out  output  4  last accepted gain
measure_mode  output  1  1 = PGA is in Vos measure mode
vos_strobe  output  1  1-cycle pulse, valid set_vos frame accepted
gain_strobe  output  1  1-cycle pulse, valid set_gain frame accepted
measure_strobe  output  1  1-cycle pulse, valid set_measure frame accepted
frame_err  output  1  1-cycle pulse, frame rejected
err_code  output  2  cause of last rejection; held until the next error

Behaviour:
Reset (wb_rst_n=0 sampled at a clk25 edge):
- All outputs go to 0.
- Synchronisers, shift register, bit counter and timeout counter are cleared; state = IDLE.
- Reset asserted mid-frame discards the partial frame with no error pulse.

Input conditioning:
- pga_clk and pga_dat each pass through a 2-flop synchroniser.
- Rising edge detect = sync2 & ~prev, one cycle wide.
- pga_dat is shifted in MSB-first in the cycle the edge is detected.

Frame format, 10 bits in transmission order:
- sync[1:0] = 2'b10
- op[1:0]: 01 set_vos, 10 set_gain, 11 set_measure, 00 reserved
- payload[4:0]
- parity: even, computed over op, payload and parity together (8 bits).

States:
- IDLE: the first rising edge shifts bit 0, sets count=1 and moves to SHIFT.
- SHIFT: each rising edge shifts one bit and increments count; when count reaches 10, move to CHECK.
  - Timeout counter clears on every edge and increments otherwise.
  - Reaching IDLE_TIMEOUT with 0<count<10 gives frame_err=1, err_code=11 (truncated), then IDLE. No drain.
- CHECK: one cycle; evaluates the frame. Error priority is sync > parity > opcode:
  - bad sync: err_code=01
  - bad parity: err_code=10
  - op=00: err_code=00
  - Any error: frame_err pulses in the cycle after CHECK, then DRAIN.
  - Valid frame: strobe and register updates take effect in the cycle after CHECK, then IDLE.
- DRAIN: ignore edges; timeout counter resets on each edge. Return to IDLE after IDLE_TIMEOUT cycles with no edge.

Register updates on valid frames:
- set_vos: offset_out ← payload, measure_mode ← 0.
- set_gain: gain_out ← payload[3:0]; payload[4] ignored; measure_mode ← 0.
- set_measure: measure_mode ← 1; payload ignored; offset_out and gain_out unchanged.

Latency and strobes:
- Strobe/frame_err asserts exactly 2 cycles after the cycle in which the 10th edge is detected.
- Exactly one of the four pulses fires per completed frame.
- Pulses are never asserted together.
- Each pulse is high for exactly one cycle.

Boundary cases:
- An edge arriving during CHECK is taken as bit 0 of a new frame, with IDLE entry in the same cycle.
  - Consequence: back-to-back frames with no gap are accepted.
- More than 10 bits in one burst: the extra bits start a new frame, which then fails sync or times out.
- pga_dat changing on the same clk25 cycle as a pga_clk rise is sampled post-synchroniser; no special handling.

Test Plan:
- Reset then frame 1 0 0 1 1 0 0 1 1 0 (set_vos, offset 5'h13, parity 0) → vos_strobe 1 cycle, offset_out=13h, measure_mode=0, frame_err never asserted.
- Frame 1 0 1 0 0 1 0 1 0 1 (set_gain 5'h0A, parity 1), then set_measure frame 1 0 1 1 0 0 0 0 0 0 → gain_out=Ah, then measure_mode=1, offset_out still 13h; followed by set_vos offset 0 → measure_mode=0.
- set_gain frame with parity bit flipped → frame_err=1, err_code=10, gain_out unchanged; edges during DRAIN are ignored; after 64 idle cycles a valid frame is accepted.
- Frame with sync 2'b11 and also bad parity → err_code=01 (priority). Frame with op=00 and correct parity → err_code=00.
- 6 bits then pga_clk idle for 64 cycles → frame_err, err_code=11 at timeout; next full valid frame accepted.
- wb_rst_n low for 1 cycle after bit 5 of a set_vos frame → all outputs 0, no strobe, no frame_err; then a clean frame is decoded. Two valid frames with zero gap → two strobes, each 2 cycles after its 10th edge.

Source files
------------

// File: rtl/pga_serial_rx.sv
// Receive-side decoder for the two-wire PGA serial link: synchronises pga_clk/pga_dat,
// frames 10-bit commands, checks sync/parity/opcode and holds the decoded PGA state.
module pga_serial_rx #(
   parameter int unsigned IDLE_TIMEOUT = 64,
   parameter int unsigned TO_WIDTH     = 7
) (
   input  logic       clk25,
   input  logic       wb_rst_n,
   input  logic       pga_dat,
   input  logic       pga_clk,
   output logic [4:0] offset_out,
   output logic [3:0] gain_out,
   output logic       measure_mode,
   output logic       vos_strobe,
   output logic       gain_strobe,
   output logic       measure_strobe,
   output logic       frame_err,
   output logic [1:0] err_code
);

   typedef enum logic [1:0] {StIdle, StShift, StCheck, StDrain} state_e;

   localparam logic [TO_WIDTH-1:0] ToLast = TO_WIDTH'(IDLE_TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [1:0]          clk_sync_q, dat_sync_q;
   logic                clk_prev_q;
   logic [9:0]          shift_q, shift_d;
   logic [3:0]          count_q, count_d;
   logic [TO_WIDTH-1:0] to_q, to_d;
   logic [4:0]          offset_q, offset_d;
   logic [3:0]          gain_q, gain_d;
   logic                measure_q, measure_d;
   logic                vos_stb_q, vos_stb_d;
   logic                gain_stb_q, gain_stb_d;
   logic                meas_stb_q, meas_stb_d;
   logic                err_q, err_d;
   logic [1:0]          err_code_q, err_code_d;

   logic bit_edge, bit_in, to_last, bad_sync, bad_parity, bad_op, frame_bad;

   assign bit_edge   = clk_sync_q[1] & ~clk_prev_q;
   assign bit_in     = dat_sync_q[1];
   assign to_last    = (to_q == ToLast);
   // shift_q layout: [9:8] sync, [7:6] op, [5:1] payload, [0] parity
   assign bad_sync   = (shift_q[9:8] != 2'b10);
   assign bad_parity = ^shift_q[7:0];
   assign bad_op     = (shift_q[7:6] == 2'b00);
   assign frame_bad  = bad_sync | bad_parity | bad_op;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      count_d    = count_q;
      to_d       = to_q;
      offset_d   = offset_q;
      gain_d     = gain_q;
      measure_d  = measure_q;
      err_code_d = err_code_q;
      vos_stb_d  = 1'b0;
      gain_stb_d = 1'b0;
      meas_stb_d = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            to_d = '0;
            if (bit_edge) begin
               shift_d = {9'd0, bit_in};
               count_d = 4'd1;
               state_d = StShift;
            end
         end
         StShift: begin
            if (bit_edge) begin
               shift_d = {shift_q[8:0], bit_in};
               count_d = count_q + 4'd1;
               to_d    = '0;
               if (count_q == 4'd9) state_d = StCheck;
            end else if (to_last) begin
               err_d      = 1'b1;
               err_code_d = 2'b11;
               count_d    = 4'd0;
               to_d       = '0;
               state_d    = StIdle;
            end else begin
               to_d = to_q + TO_WIDTH'(1);
            end
         end
         StCheck: begin
            count_d = 4'd0;
            to_d    = '0;
            if (frame_bad) begin
               err_d = 1'b1;
               if (bad_sync)        err_code_d = 2'b01;
               else if (bad_parity) err_code_d = 2'b10;
               else                 err_code_d = 2'b00;
               state_d = StDrain;
            end else begin
               unique case (shift_q[7:6])
                  2'b01: begin
                     vos_stb_d = 1'b1;
                     offset_d  = shift_q[5:1];
                     measure_d = 1'b0;
                  end
                  2'b10: begin
                     gain_stb_d = 1'b1;
                     gain_d     = shift_q[4:1];
                     measure_d  = 1'b0;
                  end
                  default: begin
                     meas_stb_d = 1'b1;
                     measure_d  = 1'b1;
                  end
               endcase
               // An edge here already belongs to the next frame.
               if (bit_edge) begin
                  shift_d = {9'd0, bit_in};
                  count_d = 4'd1;
                  state_d = StShift;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StDrain: begin
            if (bit_edge) begin
               to_d = '0;
            end else if (to_last) begin
               to_d    = '0;
               state_d = StIdle;
            end else begin
               to_d = to_q + TO_WIDTH'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk25) begin
      if (!wb_rst_n) begin
         state_q    <= StIdle;
         clk_sync_q <= 2'b00;
         dat_sync_q <= 2'b00;
         clk_prev_q <= 1'b0;
         shift_q    <= '0;
         count_q    <= '0;
         to_q       <= '0;
         offset_q   <= '0;
         gain_q     <= '0;
         measure_q  <= 1'b0;
         vos_stb_q  <= 1'b0;
         gain_stb_q <= 1'b0;
         meas_stb_q <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         clk_sync_q <= {clk_sync_q[0], pga_clk};
         dat_sync_q <= {dat_sync_q[0], pga_dat};
         clk_prev_q <= clk_sync_q[1];
         shift_q    <= shift_d;
         count_q    <= count_d;
         to_q       <= to_d;
         offset_q   <= offset_d;
         gain_q     <= gain_d;
         measure_q  <= measure_d;
         vos_stb_q  <= vos_stb_d;
         gain_stb_q <= gain_stb_d;
         meas_stb_q <= meas_stb_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign offset_out     = offset_q;
   assign gain_out       = gain_q;
   assign measure_mode   = measure_q;
   assign vos_strobe     = vos_stb_q;
   assign gain_strobe    = gain_stb_q;
   assign measure_strobe = meas_stb_q;
   assign frame_err      = err_q;
   assign err_code       = err_code_q;

endmodule

// File: tb/tb_pga_serial_rx.sv
// Scoreboard bench for pga_serial_rx: directed frames push expected events, a monitor
// pops and compares on every strobe/frame_err pulse.
module tb_pga_serial_rx;

   logic       clk25 = 1'b0;
   logic       wb_rst_n;
   logic       pga_dat;
   logic       pga_clk;
   logic [4:0] offset_out;
   logic [3:0] gain_out;
   logic       measure_mode;
   logic       vos_strobe;
   logic       gain_strobe;
   logic       measure_strobe;
   logic       frame_err;
   logic [1:0] err_code;

   pga_serial_rx #(
      .IDLE_TIMEOUT(64),
      .TO_WIDTH    (7)
   ) dut (
      .clk25         (clk25),
      .wb_rst_n      (wb_rst_n),
      .pga_dat       (pga_dat),
      .pga_clk       (pga_clk),
      .offset_out    (offset_out),
      .gain_out      (gain_out),
      .measure_mode  (measure_mode),
      .vos_strobe    (vos_strobe),
      .gain_strobe   (gain_strobe),
      .measure_strobe(measure_strobe),
      .frame_err     (frame_err),
      .err_code      (err_code)
   );

   always #5 clk25 = ~clk25;

   int cyc = 0;
   always @(posedge clk25) cyc <= cyc + 1;

   // kind: 0 vos, 1 gain, 2 measure, 3 error
   typedef struct {
      int         kind;
      logic [1:0] code;
      logic [4:0] off;
      logic [3:0] gain;
      logic       meas;
      int         at;
   } exp_t;

   exp_t       sb[$];
   int         checks   = 0;
   int         failures = 0;
   logic [4:0] m_off  = '0;
   logic [3:0] m_gain = '0;
   logic       m_meas = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_ok(input int kind, input logic [4:0] pay, input int at);
      exp_t e;
      if (kind == 0) begin m_off = pay; m_meas = 1'b0; end
      else if (kind == 1) begin m_gain = pay[3:0]; m_meas = 1'b0; end
      else m_meas = 1'b1;
      e.kind = kind; e.code = 2'b00; e.off = m_off; e.gain = m_gain; e.meas = m_meas;
      e.at = at;
      sb.push_back(e);
   endtask

   task automatic push_err(input logic [1:0] code, input int at);
      exp_t e;
      e.kind = 3; e.code = code; e.off = m_off; e.gain = m_gain; e.meas = m_meas; e.at = at;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk25);
      #1;
   endtask

   // Sends the first n bits of f MSB-first; last_rise is the cycle the final rise was driven.
   task automatic send(input logic [9:0] f, input int n, input int lo, input int hi,
                       output int last_rise);
      last_rise = -1;
      for (int i = 0; i < n; i++) begin
         pga_clk = 1'b0;
         pga_dat = f[9-i];
         step(lo);
         pga_clk   = 1'b1;
         last_rise = cyc;
         step(hi);
      end
      pga_clk = 1'b0;
   endtask

   always @(negedge clk25) begin
      int   np;
      int   act_kind;
      exp_t e;
      np = int'(vos_strobe) + int'(gain_strobe) + int'(measure_strobe) + int'(frame_err);
      if (np != 0) begin
         chk("pulse_onehot", np, 1);
         act_kind = vos_strobe ? 0 : gain_strobe ? 1 : measure_strobe ? 2 : 3;
         if (sb.size() == 0) begin
            chk("unexpected_pulse_kind", act_kind, -1);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", act_kind, e.kind);
            if (e.kind == 3) chk("err_code", int'(err_code), int'(e.code));
            chk("offset_out", int'(offset_out), int'(e.off));
            chk("gain_out", int'(gain_out), int'(e.gain));
            chk("measure_mode", int'(measure_mode), int'(e.meas));
            if (e.at >= 0) chk("pulse_latency_cycle", cyc, e.at);
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_offset"}, int'(offset_out), 0);
      chk({tag, "_gain"}, int'(gain_out), 0);
      chk({tag, "_measure"}, int'(measure_mode), 0);
      chk({tag, "_pulses"}, int'({vos_strobe, gain_strobe, measure_strobe, frame_err}), 0);
      chk({tag, "_err_code"}, int'(err_code), 0);
   endtask

   initial begin
      int r;
      int r2;
      int budget;
      wb_rst_n = 1'b0;
      pga_clk  = 1'b0;
      pga_dat  = 1'b0;
      step(3);
      chk_zero("reset");
      wb_rst_n = 1'b1;
      step(4);

      // set_vos 0x13
      send(10'b1001100110, 10, 4, 4, r); push_ok(0, 5'h13, r + 4); step(4);
      // set_gain 0x0A, set_measure, set_vos 0
      send(10'b1010010101, 10, 4, 4, r); push_ok(1, 5'h0A, r + 4); step(4);
      send(10'b1011000000, 10, 4, 4, r); push_ok(2, 5'h00, r + 4); step(4);
      send(10'b1001000001, 10, 4, 4, r); push_ok(0, 5'h00, r + 4); step(4);

      // bad parity, then a whole frame during drain that must be ignored
      send(10'b1010010100, 10, 4, 4, r); push_err(2'b10, r + 4);
      send(10'b1001100110, 10, 4, 4, r);
      step(80);
      send(10'b1010001110, 10, 4, 4, r); push_ok(1, 5'h07, r + 4); step(4);

      // sync 11 with bad parity -> sync wins; op 00 with good parity
      send(10'b1101100111, 10, 4, 4, r); push_err(2'b01, r + 4); step(80);
      send(10'b1000001010, 10, 4, 4, r); push_err(2'b00, r + 4); step(80);

      // truncated frame, timeout, then a valid frame
      send(10'b1001100110, 6, 4, 4, r); push_err(2'b11, -1); step(80);
      send(10'b1001101010, 10, 4, 4, r); push_ok(0, 5'h15, r + 4); step(4);

      // reset mid-frame: no pulse, everything back to zero
      send(10'b1001100110, 5, 4, 4, r);
      wb_rst_n = 1'b0;
      step(1);
      chk_zero("midframe_reset");
      wb_rst_n = 1'b1;
      m_off = '0; m_gain = '0; m_meas = 1'b0;
      step(4);
      send(10'b1011000000, 10, 4, 4, r); push_ok(2, 5'h00, r + 4); step(4);

      // back-to-back frames at the fastest bit rate
      send(10'b1001100110, 10, 1, 1, r);  push_ok(0, 5'h13, r + 4);
      send(10'b1010010101, 10, 1, 1, r2); push_ok(1, 5'h0A, r2 + 4);

      budget = 0;
      while (sb.size() != 0 && budget < 300) begin
         step(1);
         budget++;
      end
      chk("scoreboard_left", sb.size(), 0);
      step(5);
      chk("final_offset", int'(offset_out), 'h13);
      chk("final_gain", int'(gain_out), 'hA);
      chk("final_measure", int'(measure_mode), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
